univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the fixed 8-bit serial-in register. It adds width parametrisation, bidirectional shift, rotate, parallel load and clear modes, dual serial outputs, and a frame counter that flags each completed group of WIDTH shifts. It sits between serial links and word-wide datapaths, serving as SIPO, PISO or rotator.

---
 rtl/shift_pkg.sv | 19 +
 rtl/univ_shift_reg_frame_counter.sv | 49 ++++
 rtl/univ_shift_reg.sv | 71 +++++++
 tb/tb_univ_shift_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the universal shift register.
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SHR  = 3'b001,
        SHL  = 3'b010,
        ROR  = 3'b011,
        ROL  = 3'b100,
        LOAD = 3'b101,
        CLR  = 3'b110,
        RSVD = 3'b111
    } shift_mode_t;

    function automatic logic is_shift_op(shift_mode_t m);
        return (m == SHR) || (m == SHL) || (m == ROR) || (m == ROL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_frame_counter.sv
// Counts shift ops within a WIDTH-long frame and pulses frame_done on the last one.
module frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     step,
    input  logic                     restart,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     frame_done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (restart) begin
                cnt_d = '0;
            end else if (step) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate both ways, parallel load, clear, frame tracking.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] po,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);
    shift_mode_t      mode_e;
    logic [WIDTH-1:0] po_q, po_d;
    logic             step, restart;

    assign mode_e = shift_mode_t'(mode);

    always_comb begin
        po_d = po_q;
        if (en) begin
            case (mode_e)
                SHR:     po_d = {ser_in_r, po_q[WIDTH-1:1]};
                SHL:     po_d = {po_q[WIDTH-2:0], ser_in_l};
                ROR:     po_d = {po_q[0], po_q[WIDTH-1:1]};
                ROL:     po_d = {po_q[WIDTH-2:0], po_q[WIDTH-1]};
                LOAD:    po_d = par_in;
                CLR:     po_d = '0;
                default: po_d = po_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            po_q <= RESET_VAL;
        end else begin
            po_q <= po_d;
        end
    end

    // LOAD and CLR open a fresh frame; direction changes do not.
    assign step    = is_shift_op(mode_e);
    assign restart = (mode_e == LOAD) || (mode_e == CLR);

    frame_counter #(
        .WIDTH(WIDTH)
    ) u_frame_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .step      (step),
        .restart   (restart),
        .bit_cnt   (bit_cnt),
        .frame_done(frame_done)
    );

    assign po        = po_q;
    assign ser_out_r = po_q[0];
    assign ser_out_l = po_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed plus random stimulus for 8- and 13-bit instances against an arithmetic reference model.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, sr, sl;
    logic [2:0]  mode;
    logic [7:0]  p8;
    logic [12:0] p13;

    logic [7:0]  po8;
    logic        sor8, sol8, fd8;
    logic [2:0]  cnt8;
    logic [12:0] po13;
    logic        sor13, sol13, fd13;
    logic [3:0]  cnt13;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_po  [2];
    int          m_cnt [2];
    logic        m_fd  [2];

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .ser_in_r(sr), .ser_in_l(sl), .par_in(p8),
        .po(po8), .ser_out_r(sor8), .ser_out_l(sol8),
        .bit_cnt(cnt8), .frame_done(fd8)
    );

    univ_shift_reg #(.WIDTH(13), .RESET_VAL(13'h1A5C)) dut13 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .ser_in_r(sr), .ser_in_l(sl), .par_in(p13),
        .po(po13), .ser_out_r(sor13), .ser_out_l(sol13),
        .bit_cnt(cnt13), .frame_done(fd13)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: words as plain integers, frame position as a modulo-width count.
    function automatic void model(input int k, input logic [31:0] par);
        int          w    = (k == 0) ? 8 : 13;
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        logic [31:0] p    = m_po[k];
        bit          sh   = 1'b0;
        m_fd[k] = 1'b0;
        if (reset) begin
            m_po[k]  = (k == 0) ? 32'h0 : 32'h1A5C;
            m_cnt[k] = 0;
            return;
        end
        if (!en) return;
        case (mode)
            3'd1: begin p = (p >> 1) | (32'(sr) << (w - 1)); sh = 1'b1; end
            3'd2: begin p = ((p << 1) | 32'(sl)) & mask; sh = 1'b1; end
            3'd3: begin p = (p >> 1) | ((p & 32'd1) << (w - 1)); sh = 1'b1; end
            3'd4: begin p = ((p << 1) & mask) | (p >> (w - 1)); sh = 1'b1; end
            3'd5: begin p = par & mask; m_cnt[k] = 0; end
            3'd6: begin p = 32'd0; m_cnt[k] = 0; end
            default: ;
        endcase
        m_po[k] = p;
        if (sh) begin
            m_cnt[k]++;
            if (m_cnt[k] == w) begin
                m_cnt[k] = 0;
                m_fd[k]  = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        chk("po8",    32'(po8),   m_po[0]);
        chk("cnt8",   32'(cnt8),  32'(m_cnt[0]));
        chk("fd8",    32'(fd8),   32'(m_fd[0]));
        chk("sor8",   32'(sor8),  32'(m_po[0][0]));
        chk("sol8",   32'(sol8),  32'(m_po[0][7]));
        chk("po13",   32'(po13),  m_po[1]);
        chk("cnt13",  32'(cnt13), 32'(m_cnt[1]));
        chk("fd13",   32'(fd13),  32'(m_fd[1]));
        chk("sor13",  32'(sor13), 32'(m_po[1][0]));
        chk("sol13",  32'(sol13), 32'(m_po[1][12]));
    endtask

    task automatic step(input logic [2:0] md, input logic e, input logic r,
                        input logic s_r, input logic s_l,
                        input logic [7:0] a, input logic [12:0] b);
        mode = md; en = e; reset = r; sr = s_r; sl = s_l; p8 = a; p13 = b;
        @(posedge clk);
        model(0, 32'(a));
        model(1, 32'(b));
        #1;
        check_all();
        $display("step mode=%0d en=%0b rst=%0b po8=%02h cnt8=%0d fd8=%0b po13=%04h cnt13=%0d fd13=%0b",
                 md, e, r, po8, cnt8, fd8, po13, cnt13, fd13);
    endtask

    logic [7:0]  seq;
    logic [31:0] held;

    initial begin
        m_po[0] = '0; m_po[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0; m_fd[0] = 0; m_fd[1] = 0;
        mode = HOLD; en = 0; reset = 1; sr = 0; sl = 0; p8 = '0; p13 = '0;

        // Reset beats LOAD.
        step(LOAD, 1, 1, 0, 0, 8'hA5, 13'h0FFF);
        step(LOAD, 1, 1, 0, 0, 8'hA5, 13'h0FFF);
        chk("rst_po8", 32'(po8), 32'h00);
        chk("rst_cnt8", 32'(cnt8), 32'd0);
        chk("rst_fd8", 32'(fd8), 32'd0);
        chk("rst_po13", 32'(po13), 32'h1A5C);
        step(HOLD, 1, 0, 0, 0, 8'h00, 13'h0);

        // SIPO frame.
        seq = 8'b01001101;
        for (int i = 0; i < 8; i++) begin
            step(SHR, 1, 0, seq[i], 0, 8'h00, 13'h0);
            chk("shr_fd", 32'(fd8), 32'(i == 7));
        end
        chk("shr_po", 32'(po8), 32'h4D);
        chk("shr_cnt", 32'(cnt8), 32'd0);
        step(HOLD, 1, 0, 0, 0, 8'h00, 13'h0);
        chk("shr_fd_once", 32'(fd8), 32'd0);

        // Rotates.
        step(LOAD, 1, 0, 0, 0, 8'h81, 13'h1001);
        step(ROL, 1, 0, 0, 0, 8'h00, 13'h0);
        chk("rol_po", 32'(po8), 32'h03);
        chk("rol_sol", 32'(sol8), 32'd0);
        step(ROR, 1, 0, 0, 0, 8'h00, 13'h0);
        step(ROR, 1, 0, 0, 0, 8'h00, 13'h0);
        chk("ror_po", 32'(po8), 32'hC0);
        chk("ror_cnt", 32'(cnt8), 32'd3);

        // Enable gap mid-frame.
        step(LOAD, 1, 0, 0, 0, 8'hF0, 13'h0F0F);
        for (int i = 0; i < 3; i++) step(SHL, 1, 0, 0, 1, 8'h00, 13'h0);
        for (int i = 0; i < 2; i++) begin
            step(SHL, 0, 0, 0, 1, 8'h00, 13'h0);
            chk("en0_po", 32'(po8), 32'h87);
            chk("en0_cnt", 32'(cnt8), 32'd3);
            chk("en0_fd", 32'(fd8), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(SHL, 1, 0, 0, 1, 8'h00, 13'h0);
            chk("shl_fd", 32'(fd8), 32'(i == 4));
        end
        chk("shl_po", 32'(po8), 32'hFF);

        // Reset mid-frame discards the partial count.
        step(CLR, 1, 0, 0, 0, 8'h00, 13'h0);
        for (int i = 0; i < 5; i++) step(SHR, 1, 0, 1, 0, 8'h00, 13'h0);
        step(SHR, 1, 1, 1, 0, 8'h00, 13'h0);
        for (int i = 0; i < 8; i++) begin
            step(SHR, 1, 0, i[0], 0, 8'h00, 13'h0);
            chk("rstmid_fd", 32'(fd8), 32'(i == 7));
        end

        // Back-to-back 13-bit frames.
        step(CLR, 1, 0, 0, 0, 8'h00, 13'h0);
        for (int i = 1; i <= 39; i++) begin
            step(SHR, 1, 0, 1'($urandom_range(0, 1)), 0, 8'h00, 13'h0);
            chk("b2b_fd13", 32'(fd13), 32'((i % 13) == 0));
        end
        held = m_po[1];
        step(RSVD, 1, 0, 1, 1, 8'h00, 13'h0);
        chk("rsvd_po13", 32'(po13), held);

        // Random soak.
        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 13'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
